// File: rtl/upc_serial_tx.sv
// upc_serial_tx: 4-entry item FIFO feeding a 7-bit serial framer.
// Frame: start 0, U P C M (MSB first), even parity, stop 1; each bit
// held BAUD_DIV clocks. Back-to-back frames run with no idle gap.
module upc_serial_tx #(
    parameter int BAUD_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] upc,
    input  logic       mark,
    output logic       tx,
    output logic       busy,
    output logic [2:0] count,
    output logic       sent
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t     state, state_n;
    logic [3:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic       push, pop;
    logic [3:0] baud_cnt, baud_cnt_n;
    logic       bit_last;
    logic [1:0] bit_idx, bit_idx_n;
    logic [3:0] shreg, shreg_n;
    logic       tx_n;

    // Ready comes from the registered count only, so a pop in the same
    // cycle never frees a slot for a push while full.
    assign in_ready = (count != 3'd4);
    assign push     = in_valid && in_ready && !reset;
    assign bit_last = (baud_cnt == 4'(BAUD_DIV - 1));
    assign busy     = (state != IDLE);
    assign sent     = (state == STOP) && bit_last;

    // FIFO storage write; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {upc, mark};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Next state, pop decision and next line level
    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        pop        = 1'b0;
        baud_cnt_n = (state == IDLE || bit_last) ? 4'd0 : baud_cnt + 4'd1;
        case (state)
            IDLE: begin
                if (count != 3'd0) begin
                    pop       = 1'b1;
                    shreg_n   = mem[rd_ptr];
                    bit_idx_n = 2'd0;
                    state_n   = START;
                end
            end
            START: begin
                if (bit_last) begin
                    state_n   = DATA;
                    bit_idx_n = 2'd0;
                end
            end
            DATA: begin
                if (bit_last) begin
                    if (bit_idx == 2'd3) state_n = PARITY;
                    else                 bit_idx_n = bit_idx + 2'd1;
                end
            end
            PARITY: begin
                if (bit_last) state_n = STOP;
            end
            STOP: begin
                if (bit_last) begin
                    // Chain straight into the next frame when work is queued
                    if (count != 3'd0) begin
                        pop       = 1'b1;
                        shreg_n   = mem[rd_ptr];
                        bit_idx_n = 2'd0;
                        state_n   = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is registered from the next state so tx always
        // matches the state it is being driven for.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[~bit_idx_n];
            PARITY:  tx_n = ^shreg_n;
            default: tx_n = 1'b1;
        endcase
    end

    // Framer state registers; reset aborts any frame in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= 4'd0;
            bit_idx  <= 2'd0;
            shreg    <= 4'd0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
        end
    end

endmodule

// File: tb/tb_upc_serial_tx.sv
// Directed bench for upc_serial_tx at BAUD_DIV=2: single frames, FIFO fill
// with back-pressure, mid-frame push, and reset abort.
module tb_upc_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] upc;
    logic       mark;
    logic       tx;
    logic       busy;
    logic [2:0] count;
    logic       sent;

    int checks = 0;
    int errors = 0;
    int last_wait;
    logic [13:0] last_tx;
    logic [3:0]  exp_q [$];
    logic [3:0]  tab [6];

    upc_serial_tx #(.BAUD_DIV(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .upc(upc), .mark(mark), .tx(tx), .busy(busy), .count(count), .sent(sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected 14-sample line waveform for one item, first sample at MSB
    function automatic logic [13:0] frame_exp(input logic [3:0] it);
        logic [6:0]  b;
        logic [13:0] v;
        b = {1'b0, it, ^it, 1'b1};
        v = '0;
        for (int j = 6; j >= 0; j--) v = {v[11:0], b[j], b[j]};
        return v;
    endfunction

    // Wait for busy, then sample nfr contiguous frames against the queue
    task automatic capture(input string tag, input int nfr);
        logic [13:0] tv, sv, bv;
        logic [3:0]  it;
        int w;
        w = 0;
        @(negedge clk);
        while (!busy && w < 100) begin
            @(negedge clk);
            w++;
        end
        last_wait = w;
        if (!busy) begin
            chk({tag, "_start_timeout"}, busy, 1);
            return;
        end
        for (int f = 0; f < nfr; f++) begin
            tv = '0; sv = '0; bv = '0;
            for (int i = 0; i < 14; i++) begin
                if (f != 0 || i != 0) @(negedge clk);
                tv = {tv[12:0], tx};
                sv = {sv[12:0], sent};
                bv = {bv[12:0], busy};
            end
            it = (exp_q.size() != 0) ? exp_q.pop_front() : 4'hx;
            last_tx = tv;
            chk($sformatf("%s_f%0d_tx", tag, f), tv, frame_exp(it));
            chk($sformatf("%s_f%0d_sent", tag, f), sv, 14'h0001);
            chk($sformatf("%s_f%0d_busy", tag, f), bv, 14'h3fff);
        end
        @(negedge clk);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_tx"}, tx, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int w;
        logic bad;
        tab[0] = {3'b101, 1'b1};
        tab[1] = {3'b011, 1'b0};
        tab[2] = {3'b110, 1'b0};
        tab[3] = {3'b000, 1'b1};
        tab[4] = {3'b111, 1'b1};
        tab[5] = {3'b010, 1'b1};

        // Reset with a push offered: push must be ignored
        reset = 1'b1; in_valid = 1'b1; upc = 3'b111; mark = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", count, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_sent", sent, 0);
        reset = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_count", count, 0);

        // Single frame 101/1: count=1 after the push edge, tx low next edge
        in_valid = 1'b1; {upc, mark} = tab[0];
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_count", count, 1);
        chk("t1_tx_before", tx, 1);
        chk("t1_busy_before", busy, 0);
        exp_q.push_back(tab[0]);
        capture("t1", 1);
        chk("t1_latency", last_wait, 0);
        chk("t1_wave", last_tx, 14'b00110011111111);

        // All-zero item: parity 0
        in_valid = 1'b1; {upc, mark} = 4'b0000;
        @(negedge clk);
        in_valid = 1'b0;
        exp_q.push_back(4'b0000);
        capture("t2", 1);
        chk("t2_wave", last_tx, 14'b00000000000011);

        // Fill to full, back-pressure, reject at the pop edge, contiguous output
        fork
            capture("t3", 6);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    in_valid = 1'b1; {upc, mark} = tab[i];
                    chk($sformatf("t3_rdy%0d", i), in_ready, 1);
                    exp_q.push_back(tab[i]);
                end
                @(negedge clk);
                chk("t3_cnt_full", count, 4);
                chk("t3_rdy_full", in_ready, 0);
                {upc, mark} = tab[5];
                w = 0;
                while (!in_ready && w < 60) begin
                    @(negedge clk);
                    w++;
                end
                chk("t3_wait", w, 11);
                chk("t3_cnt_pop", count, 3);
                exp_q.push_back(tab[5]);
                @(negedge clk);
                in_valid = 1'b0;
                chk("t3_cnt_refill", count, 4);
            end
        join

        // Push during parity of frame A: A intact, B follows with no gap
        in_valid = 1'b1; {upc, mark} = tab[2];
        @(negedge clk);
        in_valid = 1'b0;
        exp_q.push_back(tab[2]);
        fork
            capture("t4", 2);
            begin
                repeat (11) @(negedge clk);
                in_valid = 1'b1; {upc, mark} = tab[4];
                exp_q.push_back(tab[4]);
                @(negedge clk);
                in_valid = 1'b0;
            end
        join

        // Reset mid-DATA with two items queued
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; {upc, mark} = tab[i];
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("t5_queued", count, 2);
        repeat (2) @(negedge clk);
        chk("t5_busy_data", busy, 1);
        reset = 1'b1; in_valid = 1'b1; {upc, mark} = tab[3];
        @(negedge clk);
        chk("t5_tx", tx, 1);
        chk("t5_busy", busy, 0);
        chk("t5_count", count, 0);
        chk("t5_sent", sent, 0);
        chk("t5_ready", in_ready, 1);
        @(negedge clk);
        chk("t5_push_ignored", count, 0);
        reset = 1'b0; in_valid = 1'b0;
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy || sent || !tx || count != 3'd0) bad = 1'b1;
        end
        chk("t5_quiet", bad, 0);
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
